// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single registered-read BRAM.
// Grants at most one operation per cycle (round-robin or A-priority), supports
// a lock so one requester can hold the BRAM across a read-modify-write, and
// keeps a one-entry hold register per requester so read data survives
// response backpressure.
module bram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                  clock,
    input  logic                  rst_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_write,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_write,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wren,
    input  logic [DATA_WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK_A   = 2'd1,
        LOCK_B   = 2'd2
    } lock_e;

    lock_e                 lock_q, lock_d;
    logic                  lastB_q, lastB_d;

    // A read issued last cycle means BRAM 'out' belongs to that requester now.
    logic                  aPend_q, aPend_d;
    logic                  bPend_q, bPend_d;
    logic                  aHoldValid_q, aHoldValid_d;
    logic                  bHoldValid_q, bHoldValid_d;
    logic [DATA_WIDTH-1:0] aHoldData_q, aHoldData_d;
    logic [DATA_WIDTH-1:0] bHoldData_q, bHoldData_d;

    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  aElig, bElig;
    logic                  grantA, grantB;
    logic                  selWrite;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic                  readIssue, writeIssue;

    // Response side: a live read result takes the port directly, otherwise the hold register.
    always_comb begin
        a_rsp_valid = aPend_q | aHoldValid_q;
        b_rsp_valid = bPend_q | bHoldValid_q;
        a_rsp_data  = '0;
        b_rsp_data  = '0;
        if (aHoldValid_q) begin
            a_rsp_data = aHoldData_q;
        end else if (aPend_q) begin
            a_rsp_data = out;
        end
        if (bHoldValid_q) begin
            b_rsp_data = bHoldData_q;
        end else if (bPend_q) begin
            b_rsp_data = out;
        end
    end

    // Eligibility, grant selection and lock/last-grant next state.
    always_comb begin
        aElig   = a_valid & (a_write | ~a_rsp_valid | a_rsp_ready);
        bElig   = b_valid & (b_write | ~b_rsp_valid | b_rsp_ready);
        grantA  = 1'b0;
        grantB  = 1'b0;
        lock_d  = lock_q;
        lastB_d = lastB_q;
        case (lock_q)
            LOCK_A:  grantA = aElig;
            LOCK_B:  grantB = bElig;
            default: begin
                if (aElig && bElig) begin
                    if (FIXED_PRIORITY || lastB_q) begin
                        grantA = 1'b1;
                    end else begin
                        grantB = 1'b1;
                    end
                end else begin
                    grantA = aElig;
                    grantB = bElig;
                end
            end
        endcase
        if (grantA) begin
            lock_d  = a_lock ? LOCK_A : UNLOCKED;
            lastB_d = 1'b0;
        end else if (grantB) begin
            lock_d  = b_lock ? LOCK_B : UNLOCKED;
            lastB_d = 1'b1;
        end
        a_ready = grantA;
        b_ready = grantB;
    end

    // BRAM command: the granted op drives the bus this cycle, idle cycles hold the last address/data.
    always_comb begin
        selWrite   = grantB ? b_write : a_write;
        selAddr    = grantB ? b_addr  : a_addr;
        selWdata   = grantB ? b_wdata : a_wdata;
        readIssue  = (grantA | grantB) & ~selWrite;
        writeIssue = (grantA | grantB) & selWrite;
        raddr_d    = readIssue  ? selAddr  : raddr_q;
        waddr_d    = writeIssue ? selAddr  : waddr_q;
        wdata_d    = writeIssue ? selWdata : wdata_q;
        raddr      = raddr_d;
        waddr      = waddr_d;
        wdata      = wdata_d;
        wren       = writeIssue;
    end

    // Read tracking: capture BRAM output into the hold register when the requester stalls.
    always_comb begin
        aPend_d      = grantA & ~a_write;
        bPend_d      = grantB & ~b_write;
        aHoldValid_d = aHoldValid_q;
        aHoldData_d  = aHoldData_q;
        bHoldValid_d = bHoldValid_q;
        bHoldData_d  = bHoldData_q;
        if (aHoldValid_q && a_rsp_ready) begin
            aHoldValid_d = 1'b0;
        end
        if (aPend_q && !a_rsp_ready) begin
            aHoldValid_d = 1'b1;
            aHoldData_d  = out;
        end
        if (bHoldValid_q && b_rsp_ready) begin
            bHoldValid_d = 1'b0;
        end
        if (bPend_q && !b_rsp_ready) begin
            bHoldValid_d = 1'b1;
            bHoldData_d  = out;
        end
    end

    // State registers; reset drops any in-flight read and clears lock and hold state at once.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lock_q       <= UNLOCKED;
            lastB_q      <= 1'b1;
            aPend_q      <= 1'b0;
            bPend_q      <= 1'b0;
            aHoldValid_q <= 1'b0;
            bHoldValid_q <= 1'b0;
            aHoldData_q  <= '0;
            bHoldData_q  <= '0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            lock_q       <= lock_d;
            lastB_q      <= lastB_d;
            aPend_q      <= aPend_d;
            bPend_q      <= bPend_d;
            aHoldValid_q <= aHoldValid_d;
            bHoldValid_q <= bHoldValid_d;
            aHoldData_q  <= aHoldData_d;
            bHoldData_q  <= bHoldData_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: byte-addressed BRAM model plus a transaction-level
// reference (expected grant, response queues, reference memory image).
module tb_bram_arbiter;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic        lock;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic        rspReady;
   } req_t;

   logic        clock;
   logic        rst_n;
   logic        a_valid, a_ready, a_write, a_lock, a_rsp_valid, a_rsp_ready;
   logic [10:0] a_addr;
   logic [31:0] a_wdata, a_rsp_data;
   logic        b_valid, b_ready, b_write, b_lock, b_rsp_valid, b_rsp_ready;
   logic [10:0] b_addr;
   logic [31:0] b_wdata, b_rsp_data;
   logic [10:0] raddr, waddr;
   logic [31:0] wdata, bramOut;
   logic        wren;

   int checks;
   int failures;

   logic [7:0]  bramMem [0:2047];
   bit          memInit;
   logic [7:0]  refMem [0:2047];
   logic [31:0] qA [$];
   logic [31:0] qB [$];
   int          lockOwner;
   bit          lastWasB;
   logic [10:0] lastRaddr;

   bram_arbiter dut (
      .clock(clock), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_lock(a_lock),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
      .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_lock(b_lock),
      .b_addr(b_addr), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
      .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
      .raddr(raddr), .waddr(waddr), .wdata(wdata), .wren(wren), .out(bramOut)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Initial memory image shared by the BRAM model and the reference; word at 0x004 is 0x12345678.
   function automatic logic [7:0] initByte(input logic [10:0] a);
      case (a)
         11'd4:   return 8'h78;
         11'd5:   return 8'h56;
         11'd6:   return 8'h34;
         11'd7:   return 8'h12;
         default: return 8'(a * 11'd29 + 11'd7);
      endcase
   endfunction

   // Little-endian unaligned word from the reference image, wrapping at the top of memory.
   function automatic logic [31:0] refWord(input logic [10:0] a);
      return {refMem[a + 11'd3], refMem[a + 11'd2], refMem[a + 11'd1], refMem[a]};
   endfunction

   // BRAM model: byte-lane writes, registered read with one cycle of latency.
   always @(posedge clock) begin
      if (!memInit) begin
         for (int i = 0; i < 2048; i++) bramMem[i] <= initByte(11'(i));
         memInit <= 1'b1;
      end else begin
         if (wren) begin
            for (int i = 0; i < 4; i++) bramMem[waddr + 11'(i)] <= wdata[8*i +: 8];
         end
         bramOut <= {bramMem[raddr + 11'd3], bramMem[raddr + 11'd2],
                     bramMem[raddr + 11'd1], bramMem[raddr]};
      end
   end

   // One comparison: counted, and reported on a miss.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   function automatic req_t mk(input logic v, input logic w, input logic l,
                               input logic [10:0] a, input logic [31:0] d, input logic rr);
      req_t r;
      r.valid = v; r.write = w; r.lock = l; r.addr = a; r.wdata = d; r.rspReady = rr;
      return r;
   endfunction

   task automatic modelReset();
      qA.delete();
      qB.delete();
      lockOwner = 0;
      lastWasB  = 1'b1;
      lastRaddr = '0;
   endtask

   // Drive one cycle of requests, check the combinational response, then advance the reference at the edge.
   task automatic applyStimulus(input req_t ra, input req_t rb);
      bit aOut, bOut, aElig, bElig, expA, expB, rdAcc, wrAcc;
      req_t sel;
      logic [10:0] expRaddr;
      a_valid = ra.valid; a_write = ra.write; a_lock = ra.lock;
      a_addr = ra.addr; a_wdata = ra.wdata; a_rsp_ready = ra.rspReady;
      b_valid = rb.valid; b_write = rb.write; b_lock = rb.lock;
      b_addr = rb.addr; b_wdata = rb.wdata; b_rsp_ready = rb.rspReady;
      #1;
      aOut  = (qA.size() != 0);
      bOut  = (qB.size() != 0);
      aElig = ra.valid && (ra.write || !aOut || ra.rspReady);
      bElig = rb.valid && (rb.write || !bOut || rb.rspReady);
      expA  = 1'b0;
      expB  = 1'b0;
      if (lockOwner == 1) expA = aElig;
      else if (lockOwner == 2) expB = bElig;
      else if (aElig && bElig) begin
         if (lastWasB) expA = 1'b1; else expB = 1'b1;
      end else begin
         expA = aElig;
         expB = bElig;
      end
      sel      = expB ? rb : ra;
      rdAcc    = (expA || expB) && !sel.write;
      wrAcc    = (expA || expB) && sel.write;
      expRaddr = rdAcc ? sel.addr : lastRaddr;

      checkOutput("a_ready", a_ready, expA);
      checkOutput("b_ready", b_ready, expB);
      checkOutput("a_rsp_valid", a_rsp_valid, aOut);
      checkOutput("b_rsp_valid", b_rsp_valid, bOut);
      if (aOut) checkOutput("a_rsp_data", a_rsp_data, qA[0]);
      if (bOut) checkOutput("b_rsp_data", b_rsp_data, qB[0]);
      checkOutput("wren", wren, wrAcc);
      if (wrAcc) begin
         checkOutput("waddr", waddr, sel.addr);
         checkOutput("wdata", wdata, sel.wdata);
      end
      checkOutput("raddr", raddr, expRaddr);

      @(posedge clock);
      if (aOut && ra.rspReady) void'(qA.pop_front());
      if (bOut && rb.rspReady) void'(qB.pop_front());
      if (wrAcc) begin
         for (int i = 0; i < 4; i++) refMem[sel.addr + 11'(i)] = sel.wdata[8*i +: 8];
      end
      if (rdAcc) begin
         if (expA) qA.push_back(refWord(sel.addr));
         else qB.push_back(refWord(sel.addr));
         lastRaddr = sel.addr;
      end
      if (expA) begin
         lockOwner = ra.lock ? 1 : 0;
         lastWasB  = 1'b0;
      end else if (expB) begin
         lockOwner = rb.lock ? 2 : 0;
         lastWasB  = 1'b1;
      end
      #1;
   endtask

   task automatic checkIdleReset();
      checkOutput("rst_a_rsp_valid", a_rsp_valid, 1'b0);
      checkOutput("rst_b_rsp_valid", b_rsp_valid, 1'b0);
      checkOutput("rst_a_rsp_data", a_rsp_data, 32'h0);
      checkOutput("rst_b_rsp_data", b_rsp_data, 32'h0);
      checkOutput("rst_raddr", raddr, 11'h0);
      checkOutput("rst_waddr", waddr, 11'h0);
      checkOutput("rst_wdata", wdata, 32'h0);
      checkOutput("rst_wren", wren, 1'b0);
      checkOutput("rst_a_ready", a_ready, 1'b0);
      checkOutput("rst_b_ready", b_ready, 1'b0);
   endtask

   // Directed scenarios followed by a randomized run, all against the reference.
   initial begin
      req_t idle;
      req_t ra, rb;
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 2048; i++) refMem[i] = initByte(11'(i));
      modelReset();
      idle = mk(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 1'b1);
      a_valid = 0; a_write = 0; a_lock = 0; a_addr = '0; a_wdata = '0; a_rsp_ready = 1;
      b_valid = 0; b_write = 0; b_lock = 0; b_addr = '0; b_wdata = '0; b_rsp_ready = 1;
      rst_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkIdleReset();
      rst_n = 1'b1;

      $display("[TB] both requesters valid every cycle: A first, then alternate");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'(16 + i), 32'h0, 1'b1),
                       mk(1'b1, 1'b0, 1'b0, 11'(64 + i), 32'h0, 1'b1));
      end
      applyStimulus(idle, idle);

      $display("[TB] A reads 0x004 alone");
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'h004, 32'h0, 1'b1), idle);
      checkOutput("a_rsp_data_0x004", a_rsp_data, 32'h12345678);
      applyStimulus(idle, idle);

      $display("[TB] A writes 0x003, B reads it back next cycle");
      applyStimulus(mk(1'b1, 1'b1, 1'b0, 11'h003, 32'hDEADBEEF, 1'b1), idle);
      applyStimulus(idle, mk(1'b1, 1'b0, 1'b0, 11'h003, 32'h0, 1'b1));
      checkOutput("b_rsp_data_0x003", b_rsp_data, 32'hDEADBEEF);
      applyStimulus(idle, idle);

      $display("[TB] A response backpressure while B writes");
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'h010, 32'h0, 1'b0), idle);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'h020, 32'h0, 1'b0),
                       mk(1'b1, 1'b1, 1'b0, 11'(11'h010 + i), 32'(32'hA5A50000 + i), 1'b1));
      end
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'h020, 32'h0, 1'b1),
                    mk(1'b1, 1'b1, 1'b0, 11'h100, 32'h01020304, 1'b1));
      applyStimulus(idle, idle);
      applyStimulus(idle, idle);

      $display("[TB] A locked read-modify-write with B waiting");
      applyStimulus(idle, mk(1'b1, 1'b1, 1'b0, 11'h200, 32'h11111111, 1'b1));
      applyStimulus(mk(1'b1, 1'b0, 1'b1, 11'h040, 32'h0, 1'b1),
                    mk(1'b1, 1'b1, 1'b0, 11'h204, 32'h22222222, 1'b1));
      applyStimulus(idle, mk(1'b1, 1'b1, 1'b0, 11'h204, 32'h22222222, 1'b1));
      applyStimulus(mk(1'b1, 1'b1, 1'b0, 11'h040, 32'hCAFEF00D, 1'b1),
                    mk(1'b1, 1'b1, 1'b0, 11'h204, 32'h22222222, 1'b1));
      applyStimulus(idle, mk(1'b1, 1'b1, 1'b0, 11'h204, 32'h22222222, 1'b1));
      applyStimulus(idle, mk(1'b1, 1'b0, 1'b0, 11'h040, 32'h0, 1'b1));
      applyStimulus(idle, idle);

      $display("[TB] reset in the cycle after a read accept");
      applyStimulus(idle, mk(1'b1, 1'b0, 1'b0, 11'h300, 32'h0, 1'b1));
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'h008, 32'h0, 1'b1), idle);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkIdleReset();
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;
      modelReset();
      applyStimulus(idle, idle);
      applyStimulus(mk(1'b1, 1'b0, 1'b0, 11'h00C, 32'h0, 1'b1),
                    mk(1'b1, 1'b0, 1'b0, 11'h010, 32'h0, 1'b1));
      applyStimulus(idle, idle);
      applyStimulus(idle, idle);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 500; n++) begin
         ra = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 11'($urandom), $urandom, $urandom_range(0, 3) != 0);
         rb = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 11'($urandom), $urandom, $urandom_range(0, 3) != 0);
         applyStimulus(ra, rb);
      end
      for (int n = 0; n < 4; n++) applyStimulus(idle, idle);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
